// File: rtl/uart_sched_pkg.sv
// Shared types and constants for the UART report scheduler.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package uart_sched_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SEND,
    WAIT
  } state_t;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

  // Header byte is {source id, payload length}
  localparam int SRC_W = 4;
  localparam int LEN_W = 4;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: picks the first asserted request at or after ptr, wrapping cyclically.
// Latency: purely combinational; the rotating pointer lives in the parent.
// Backpressure: enable=0 forces an empty grant, so nothing is granted while the parent is busy.
//
// Ports:
//   req       in  NUM_REQ  request vector
//   ptr       in  IDX_W    highest-priority index for this cycle
//   enable    in  1        arbitration allowed
//   grant     out NUM_REQ  one-hot grant (all zero when no request or disabled)
//   grant_idx out IDX_W    binary index of the granted requester
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  input  logic               enable,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx
);

  always_comb begin
    logic found;
    int   j;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    j         = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      // ptr is always < NUM_REQ, so one conditional subtract is a full wrap
      j = int'(ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (enable && !found && req[j]) begin
        grant[j]  = 1'b1;
        grant_idx = IDX_W'(j);
        found     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_report_sched.sv
// Shares one uart_tcvr transmitter between NUM_REQ reporters; frames SYNC, header, payload (+checksum).
// Latency: grant -> first strobe 2 cycles; completion edge -> next strobe 1 cycle.
// Backpressure: one byte in flight; waits for a rising uart_data_sent before the next strobe.
//
// Ports:
//   clock, reset_n              clock and asynchronous active-low reset
//   req_valid/req_len/req_data  per-requester packet, held stable until req_ack
//   req_ack                     one-cycle pulse when the packet has been copied into the buffer
//   send_uart_data/uart_data    one-cycle byte strobe to uart_tcvr; uart_data held until the next byte
//   uart_data_sent              uart_tcvr completion level; only its rising edge in WAIT counts
//   busy                        high from grant until the packet completes
//   pkt_done                    one-cycle pulse in the cycle of the last byte's completion edge
// Build option: define UART_CHECKSUM_EN to append an XOR checksum of header and payload.
module uart_report_sched
  import uart_sched_pkg::*;
#(
  parameter int         NUM_REQ   = 2,
  parameter int         MAX_LEN   = 8,
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*4-1:0]       req_len,
  input  logic [NUM_REQ*MAX_LEN*8-1:0] req_data,
  output logic [NUM_REQ-1:0]         req_ack,
  output logic                       send_uart_data,
  output logic [7:0]                 uart_data,
  input  logic                       uart_data_sent,
  output logic                       busy,
  output logic                       pkt_done
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  // Byte index covers SYNC + header + 15 payload + checksum
  localparam int CNT_W = 5;
  localparam logic [LEN_W-1:0] MAX_LEN_C = LEN_W'(MAX_LEN);

  state_t                 state, state_nxt;
  logic                   sent_q;
  logic                   done_edge;
  logic [IDX_W-1:0]       rr_ptr;
  logic [NUM_REQ-1:0]     grant;
  logic [IDX_W-1:0]       grant_idx;
  logic                   grant_vld;
  logic [LEN_W-1:0]       grant_len;
  logic [LEN_W-1:0]       len_clamped;
  logic [SRC_W-1:0]       src_q;
  logic [LEN_W-1:0]       len_q;
  logic [MAX_LEN*8-1:0]   pay_q;
  logic [CNT_W-1:0]       idx_q;
  logic [CNT_W-1:0]       nxt_idx;
  logic [CNT_W-1:0]       last_idx;
  logic [7:0]             nxt_data;
  logic                   nxt_is_body;
  logic                   more;
`ifdef UART_CHECKSUM_EN
  logic [7:0]             csum_q;
`endif

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .req       (req_valid),
    .ptr       (rr_ptr),
    .enable    (state == IDLE),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign grant_vld   = |grant;
  assign grant_len   = req_len[int'(grant_idx)*LEN_W +: LEN_W];
  assign len_clamped = (grant_len > MAX_LEN_C) ? MAX_LEN_C : grant_len;

  // A level left high from an earlier byte never looks like a completion
  assign done_edge = uart_data_sent & ~sent_q;

`ifdef UART_CHECKSUM_EN
  assign last_idx = CNT_W'(len_q) + CNT_W'(2);
`else
  assign last_idx = CNT_W'(len_q) + CNT_W'(1);
`endif
  assign more = (idx_q != last_idx);

  // Byte that follows the one currently on uart_data
  always_comb begin
    nxt_idx     = idx_q + CNT_W'(1);
    nxt_data    = 8'h00;
    nxt_is_body = 1'b0;
    if (nxt_idx == CNT_W'(1)) begin
      nxt_data    = {src_q, len_q};
      nxt_is_body = 1'b1;
    end else if (nxt_idx <= CNT_W'(len_q) + CNT_W'(1)) begin
      nxt_is_body = 1'b1;
      for (int k = 0; k < MAX_LEN; k++) begin
        if (nxt_idx == CNT_W'(k + 2)) nxt_data = pay_q[k*8 +: 8];
      end
    end
`ifdef UART_CHECKSUM_EN
    else begin
      nxt_data = csum_q;
    end
`endif
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    send_uart_data = 1'b0;
    pkt_done       = 1'b0;
    case (state)
      IDLE: if (grant_vld) state_nxt = LOAD;
      LOAD: state_nxt = SEND;
      SEND: begin
        send_uart_data = 1'b1;
        state_nxt      = WAIT;
      end
      WAIT: begin
        if (done_edge) begin
          if (more) begin
            state_nxt = SEND;
          end else begin
            pkt_done  = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sent_q    <= 1'b0;
      rr_ptr    <= '0;
      req_ack   <= '0;
      busy      <= 1'b0;
      uart_data <= 8'h00;
      src_q     <= '0;
      len_q     <= '0;
      pay_q     <= '0;
      idx_q     <= '0;
`ifdef UART_CHECKSUM_EN
      csum_q    <= 8'h00;
`endif
    end else begin
      sent_q  <= uart_data_sent;
      req_ack <= grant;
      case (state)
        IDLE: begin
          if (grant_vld) begin
            src_q  <= SRC_W'(grant_idx);
            len_q  <= len_clamped;
            pay_q  <= req_data[int'(grant_idx)*MAX_LEN*8 +: MAX_LEN*8];
            rr_ptr <= (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + IDX_W'(1);
            busy   <= 1'b1;
          end
        end
        LOAD: begin
          idx_q     <= '0;
          uart_data <= SYNC_BYTE;
`ifdef UART_CHECKSUM_EN
          csum_q    <= 8'h00;
`endif
        end
        WAIT: begin
          if (done_edge) begin
            if (more) begin
              idx_q     <= nxt_idx;
              uart_data <= nxt_data;
`ifdef UART_CHECKSUM_EN
              if (nxt_is_body) csum_q <= csum_q ^ nxt_data;
`endif
            end else begin
              busy <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

`ifndef UART_CHECKSUM_EN
  // Only the checksum path consumes this flag
  logic unused_body;
  assign unused_body = nxt_is_body;
`endif

endmodule

// File: tb/tb_uart_report_sched.sv
module tb_uart_report_sched;

  localparam int         NUM  = 2;
  localparam int         MAXL = 8;
  localparam logic [7:0] SYNC = 8'hA5;

  logic                  clock = 1'b0;
  logic                  reset_n;
  logic [NUM-1:0]        req_valid;
  logic [NUM*4-1:0]      req_len;
  logic [NUM*MAXL*8-1:0] req_data;
  logic [NUM-1:0]        req_ack;
  logic                  send_uart_data;
  logic [7:0]            uart_data;
  logic                  uart_data_sent;
  logic                  busy;
  logic                  pkt_done;

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;
  int pkt_cnt = 0;

  // transmitter model controls
  int lat      = 540;
  int hold_cyc = 20;
  bit sticky   = 1'b0;

  // observed / expected streams
  logic [7:0] obs_q[$];
  logic [7:0] exp_q[$];
  int         ack_q[$];
  int         exp_ack_q[$];

  // requester contents
  logic [7:0] pay[NUM][MAXL];
  logic [3:0] len_tb[NUM];
  int         model_ptr = 0;

  // monitor state
  int nstb      = 0;
  int last_rise = 0;
  bit prev_send = 1'b0;
  bit prev_sent = 1'b0;

  uart_report_sched #(
    .NUM_REQ   (NUM),
    .MAX_LEN   (MAXL),
    .SYNC_BYTE (SYNC)
  ) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .req_valid      (req_valid),
    .req_len        (req_len),
    .req_data       (req_data),
    .req_ack        (req_ack),
    .send_uart_data (send_uart_data),
    .uart_data      (uart_data),
    .uart_data_sent (uart_data_sent),
    .busy           (busy),
    .pkt_done       (pkt_done)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, want);
    end
  endtask

  // uart_tcvr stand-in: completion edge 'lat' cycles after each strobe.
  // In sticky mode the completion level stays high through the next strobe.
  initial begin
    uart_data_sent = 1'b0;
    forever begin
      @(negedge clock);
      if (send_uart_data && reset_n) begin
        if (sticky) begin
          repeat (hold_cyc) @(posedge clock);
          #1 uart_data_sent = 1'b0;
          repeat (lat) @(posedge clock);
          #1 uart_data_sent = 1'b1;
        end else begin
          @(posedge clock);
          #1 uart_data_sent = 1'b0;
          repeat (lat - 1) @(posedge clock);
          #1 uart_data_sent = 1'b1;
          @(posedge clock);
          #1 uart_data_sent = 1'b0;
        end
      end
    end
  end

  // Byte capture plus strobe-shape and edge-to-strobe timing checks
  always @(negedge clock) begin
    bit rise;
    if (!reset_n) begin
      nstb      = 0;
      prev_send = 1'b0;
      prev_sent = uart_data_sent;
    end else begin
      rise = uart_data_sent && !prev_sent;
      if (rise) last_rise = cyc;
      if (send_uart_data) begin
        obs_q.push_back(uart_data);
        chk("strobe_width", 32'(prev_send), 0);
        if (nstb > 0) chk("edge_to_strobe_gap", cyc - last_rise, 1);
        nstb++;
      end
      if (pkt_done) begin
        chk("pkt_done_on_edge", 32'(rise), 1);
        pkt_cnt++;
        nstb = 0;
      end
      prev_send = send_uart_data;
      prev_sent = uart_data_sent;
    end
  end

  task automatic drive(input logic [NUM-1:0] mask);
    for (int i = 0; i < NUM; i++) begin
      req_len[i*4 +: 4] = len_tb[i];
      for (int k = 0; k < MAXL; k++) req_data[(i*MAXL+k)*8 +: 8] = pay[i][k];
    end
    req_valid = mask;
  endtask

  // Reference: serve all pending requesters in round-robin order, append framed bytes
  task automatic model_serve(input logic [NUM-1:0] mask);
    logic [NUM-1:0] pend;
    int g, lc;
    logic [7:0] hdr, cs;
    pend = mask;
    while (pend != '0) begin
      g = -1;
      for (int k = 0; k < NUM; k++)
        if (g < 0 && pend[(model_ptr + k) % NUM]) g = (model_ptr + k) % NUM;
      pend[g]   = 1'b0;
      model_ptr = (g + 1) % NUM;
      exp_ack_q.push_back(g);
      lc  = (int'(len_tb[g]) > MAXL) ? MAXL : int'(len_tb[g]);
      hdr = {4'(g), 4'(lc)};
      cs  = hdr;
      exp_q.push_back(SYNC);
      exp_q.push_back(hdr);
      for (int k = 0; k < lc; k++) begin
        exp_q.push_back(pay[g][k]);
        cs = cs ^ pay[g][k];
      end
`ifdef UART_CHECKSUM_EN
      exp_q.push_back(cs);
`endif
    end
  endtask

  // Run until npk more packets complete; requesters withdraw once acknowledged
  task automatic serve(input int npk);
    int n, target, budget;
    logic [NUM-1:0] acked;
    n      = 0;
    target = pkt_cnt + npk;
    budget = exp_q.size() * (lat + hold_cyc + 4) + 200;
    while (pkt_cnt < target) begin
      @(negedge clock);
      acked = req_ack;
      if (req_ack != '0) begin
        chk("ack_onehot", 32'($onehot(req_ack)), 1);
        chk("busy_at_ack", 32'(busy), 1);
        for (int i = 0; i < NUM; i++) if (req_ack[i]) ack_q.push_back(i);
      end
      @(posedge clock);
      #1 req_valid = req_valid & ~acked;
      n++;
      if (n > budget) begin
        chk("serve_timeout", pkt_cnt, target);
        break;
      end
    end
    @(negedge clock);
    chk("busy_after_done", 32'(busy), 0);
    @(posedge clock);
    #1;
  endtask

  task automatic compare(input string tag);
    chk({tag, "_byte_count"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      chk($sformatf("%s_byte%0d", tag, i), obs_q[i], exp_q[i]);
    chk({tag, "_ack_count"}, ack_q.size(), exp_ack_q.size());
    for (int i = 0; i < exp_ack_q.size() && i < ack_q.size(); i++)
      chk($sformatf("%s_ack%0d", tag, i), ack_q[i], exp_ack_q[i]);
    obs_q.delete();
    exp_q.delete();
    ack_q.delete();
    exp_ack_q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req_ack"}, 32'(req_ack), 0);
    chk({tag, "_send"}, 32'(send_uart_data), 0);
    chk({tag, "_uart_data"}, 32'(uart_data), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_pkt_done"}, 32'(pkt_done), 0);
  endtask

  initial begin
    int n;
    logic [NUM-1:0] mask;
    reset_n   = 1'b0;
    req_valid = '0;
    req_len   = '0;
    req_data  = '0;
    for (int i = 0; i < NUM; i++) begin
      len_tb[i] = 4'd0;
      for (int k = 0; k < MAXL; k++) pay[i][k] = 8'h00;
    end

    // Reset values
    repeat (4) @(posedge clock);
    #1 check_reset_outputs("reset");
    reset_n = 1'b1;
    repeat (2) @(posedge clock);
    #1;

    // Simultaneous pair from pointer 0, then a second pair
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < NUM; i++) begin
        len_tb[i] = 4'($urandom_range(1, 3));
        for (int k = 0; k < MAXL; k++) pay[i][k] = 8'($urandom);
      end
      drive(2'b11);
      model_serve(2'b11);
      serve(2);
      compare($sformatf("pair%0d", r));
    end

    // Requester 0, two bytes AB DE
    len_tb[0] = 4'd2;
    pay[0][0] = 8'hAB;
    pay[0][1] = 8'hDE;
    drive(2'b01);
    model_serve(2'b01);
    serve(1);
    compare("req0_len2");

    // Requester 1, empty payload
    len_tb[1] = 4'd0;
    drive(2'b10);
    model_serve(2'b10);
    serve(1);
    compare("req1_len0");

    // Oversized length clamps to MAX_LEN
    len_tb[0] = 4'hF;
    for (int k = 0; k < MAXL; k++) pay[0][k] = 8'($urandom);
    drive(2'b01);
    model_serve(2'b01);
    serve(1);
    compare("len_clamp");

    // Completion level held high across the next strobe
    sticky    = 1'b1;
    len_tb[1] = 4'd1;
    pay[1][0] = 8'($urandom);
    drive(2'b10);
    model_serve(2'b10);
    serve(1);
    compare("sent_held_high");
    sticky = 1'b0;

    // Reset during the third byte's wait, request left asserted
    len_tb[1] = 4'd3;
    for (int k = 0; k < MAXL; k++) pay[1][k] = 8'($urandom);
    drive(2'b10);
    model_serve(2'b10);
    n = 0;
    while (obs_q.size() < 3 && n < 5000) begin
      @(posedge clock);
      n++;
    end
    chk("third_strobe_reached", 32'(obs_q.size() >= 3), 1);
    repeat (100) @(posedge clock);
    #3 reset_n = 1'b0;
    #1 check_reset_outputs("mid_reset");
    for (int i = 0; i < 3 && i < obs_q.size(); i++)
      chk($sformatf("abort_byte%0d", i), obs_q[i], exp_q[i]);
    obs_q.delete();
    exp_q.delete();
    ack_q.delete();
    exp_ack_q.delete();
    repeat (600) @(posedge clock);
    #1 reset_n = 1'b1;
    model_ptr = 0;
    model_serve(2'b10);
    serve(1);
    compare("restart");

    // Randomised packets and request mixes with shorter transmit latency
    for (int r = 0; r < 6; r++) begin
      lat  = $urandom_range(2, 40);
      mask = 2'($urandom_range(1, 3));
      for (int i = 0; i < NUM; i++) begin
        len_tb[i] = 4'($urandom_range(0, 15));
        for (int k = 0; k < MAXL; k++) pay[i][k] = 8'($urandom);
      end
      drive(mask);
      model_serve(mask);
      serve((mask == 2'b11) ? 2 : 1);
      compare($sformatf("rand%0d", r));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/uart_report_sched.md
Name: uart_report_sched

Overview:
- Scheduler that shares the single uart_tcvr transmitter between NUM_REQ result producers, e.g. the detection-result and debug-status reporters.
- Arbitrates round-robin and latches the winner's packet into a local buffer.
- Frames the packet as SYNC, header, payload and optional checksum.
- Drives uart_tcvr one byte at a time through its send_uart_data / uart_data_sent handshake.

Parameters:
- NUM_REQ, 2: number of requesters; 1..16.
- MAX_LEN, 8: max payload bytes per packet; 1..15.
- SYNC_BYTE, 8'hA5: first byte of every packet.

Ports:
- clock  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  requester i has a packet; data/len held stable until req_ack[i]
- req_len  in  NUM_REQ*4  payload length per requester; packed, requester i at [4i+3:4i]
- req_data  in  NUM_REQ*MAX_LEN*8  payload per requester; byte k of requester i at [(i*MAX_LEN+k)*8 +: 8]
- req_ack  out  NUM_REQ  one-cycle pulse when requester i's packet is latched
- send_uart_data  out  1  one-cycle strobe to uart_tcvr
- uart_data  out  8  byte to transmit; valid in the strobe cycle
- uart_data_sent  in  1  uart_tcvr completion; rising edge means byte done
- busy  out  1  high from grant until packet done
- pkt_done  out  1  one-cycle pulse after the last byte's completion edge

Behaviour:
- Reset, asynchronous on reset_n=0:
  - State IDLE; req_ack=0, send_uart_data=0, uart_data=8'h00, busy=0, pkt_done=0.
  - Round-robin pointer=0; sent_q (registered uart_data_sent)=0.
  - Reset mid-packet abandons the packet; no resume.
- Completion detect: done_edge = uart_data_sent & ~sent_q.
- IDLE:
  - If any req_valid: grant the first valid index at or after the pointer, searching cyclically.
  - Same cycle: latch len (clamped to MAX_LEN) and payload into the buffer, and pulse req_ack[grant].
  - Pointer <= grant+1, modulo NUM_REQ. busy<=1. Go to LOAD.
- LOAD: byte index=0; select SYNC_BYTE. Go to SEND.
- SEND: send_uart_data=1 for exactly one cycle with uart_data=current byte. Go to WAIT.
- WAIT:
  - Hold uart_data; wait for done_edge. A sent level that stays high from before SEND is not a completion.
  - On done_edge: if more bytes remain, advance index and go to SEND the next cycle. The gap between a completion edge and the next strobe is exactly 1 cycle.
  - Otherwise pulse pkt_done, busy<=0, go to IDLE.
  - The new grant may occur in the cycle after pkt_done.
- Byte order:
  - SYNC_BYTE.
  - Header = {src_id[3:0], len[3:0]}.
  - payload[0..len-1].
  - Checksum, only when the feature is enabled.
- Total bytes = 2 + len (+1 with the checksum).
- len=0: SYNC and header only (plus checksum if enabled).
- req_valid dropping after req_ack has no effect.
- req_valid rising during a packet waits for IDLE.
- Simultaneous requests: exactly one grant per cycle; at most one req_ack bit high.
- uart_data_sent edges outside WAIT are ignored.

Optional Feature:
- Macro UART_CHECKSUM_EN.
- Defined: running XOR of header and payload bytes (SYNC excluded), cleared in LOAD, sent as the final byte.
- Undefined: no checksum register and no final byte; the packet ends after the last payload byte, or after the header when len=0.

Decomposition:
- Package uart_sched_pkg:
  - state enum {IDLE, LOAD, SEND, WAIT}.
  - SYNC_BYTE default constant.
  - Header field widths: SRC_W=4, LEN_W=4.
- Sub-module rr_arbiter (NUM_REQ):
  - Inputs: req, ptr, enable.
  - Outputs: one-hot grant and grant index. Purely combinational, with the pointer register kept in the parent.

Test Plan (bench models uart_tcvr by pulsing uart_data_sent 540 cycles after each strobe; 54 clocks/baud, 10 bits):
- Requester 0, len=2, data {8'hAB, 8'hDE} -> strobes A5, 02, AB, DE (+ 77 with UART_CHECKSUM_EN); one req_ack[0]; pkt_done after the last edge; busy low afterwards.
- Both requesters valid in the same cycle, pointer=0 -> requester 0 fully sent (header 8'h0x), then requester 1 (header 8'h1x); the next simultaneous pair grants 0 again only after 1 has been served.
- Requester 1, len=0 -> A5, 10 (+ checksum 10); pkt_done follows.
- req_len=4'hF with MAX_LEN=8 -> header low nibble 8, exactly 8 payload bytes.
- uart_data_sent held high before SEND -> no advance until the next rising edge; each strobe exactly 1 cycle wide; 1-cycle gap after each edge.
- Assert reset_n low during the third byte's WAIT -> all outputs at reset values immediately; after release with req_valid still high, a new packet restarts with A5.
